// File: rtl/dac_spi_serializer.sv
// Serializes 8-bit waveform samples into 16-bit MCP4921-style SPI write frames.
// Optional macro DAC_SPI_LDAC_EN adds an ldac_n strobe that pulses low during the deselect gap.
module dac_spi_serializer #(
    parameter int         CLK_DIV  = 2,
    parameter int         DATA_W   = 8,
    parameter int         DAC_W    = 12,
    parameter logic [3:0] CMD_BITS = 4'b0011
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi,
    output logic              busy,
`ifdef DAC_SPI_LDAC_EN
    output logic              ldac_n,
`endif
    output logic              frame_done
);

    localparam int FRAME_W = 4 + DAC_W;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   div_cnt_reg;
    logic [BIT_W-1:0]   bit_cnt_reg;
    // Holds only the bits still to be sent; the MSB goes straight to mosi on accept.
    logic [FRAME_W-2:0] shift_reg;
    logic [FRAME_W-1:0] frame_word;
    logic               accept;
    logic               div_last;

    assign frame_word = {CMD_BITS, DAC_W'(sample_in) << (DAC_W - DATA_W)};
    assign accept     = sample_valid & sample_ready;
    assign div_last   = (div_cnt_reg == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            sample_ready <= 1'b0;
            cs_n         <= 1'b1;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
`ifdef DAC_SPI_LDAC_EN
            ldac_n       <= 1'b1;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sample_ready <= 1'b1;
                    if (accept) begin
                        shift_reg    <= frame_word[FRAME_W-2:0];
                        mosi         <= frame_word[FRAME_W-1];
                        cs_n         <= 1'b0;
                        busy         <= 1'b1;
                        sample_ready <= 1'b0;
                        div_cnt_reg  <= '0;
                        bit_cnt_reg  <= '0;
                        state_reg    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        sclk        <= 1'b1;
                        state_reg   <= SHIFT;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!div_last) begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end else begin
                        div_cnt_reg <= '0;
                        if (sclk) begin
                            // Falling edge: present the next bit for the following rising edge.
                            sclk      <= 1'b0;
                            mosi      <= shift_reg[FRAME_W-2];
                            shift_reg <= {shift_reg[FRAME_W-3:0], 1'b0};
                        end else if (bit_cnt_reg == BIT_W'(FRAME_W - 1)) begin
                            state_reg <= HOLD;
                        end else begin
                            sclk        <= 1'b1;
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        cs_n        <= 1'b1;
                        mosi        <= 1'b0;
                        frame_done  <= 1'b1;
                        state_reg   <= GAP;
`ifdef DAC_SPI_LDAC_EN
                        ldac_n      <= 1'b0;
`endif
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (div_last) begin
                        div_cnt_reg  <= '0;
                        busy         <= 1'b0;
                        sample_ready <= 1'b1;
                        state_reg    <= IDLE;
`ifdef DAC_SPI_LDAC_EN
                        ldac_n       <= 1'b1;
`endif
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed bench for dac_spi_serializer: CLK_DIV=2 instance for the main scenarios,
// CLK_DIV=1 instance for fast timing and the optional ldac_n strobe.
module tb_dac_spi_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sample_valid;
    logic [7:0] sample_in;
    logic       sample_ready, cs_n, sclk, mosi, busy, frame_done;
    logic       rst1, sample_valid1;
    logic [7:0] sample_in1;
    logic       sample_ready1, cs_n1, sclk1, mosi1, busy1, frame_done1;
`ifdef DAC_SPI_LDAC_EN
    logic       ldac_n, ldac_n1;
`endif

    dac_spi_serializer #(.CLK_DIV(2)) dut (
        .Clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .busy(busy),
`ifdef DAC_SPI_LDAC_EN
        .ldac_n(ldac_n),
`endif
        .frame_done(frame_done)
    );

    dac_spi_serializer #(.CLK_DIV(1)) dut1 (
        .Clk(clk), .rst(rst1), .sample_in(sample_in1), .sample_valid(sample_valid1),
        .sample_ready(sample_ready1), .cs_n(cs_n1), .sclk(sclk1), .mosi(mosi1), .busy(busy1),
`ifdef DAC_SPI_LDAC_EN
        .ldac_n(ldac_n1),
`endif
        .frame_done(frame_done1)
    );

    int total = 0;
    int bad   = 0;

    // Frame monitor for the CLK_DIV=2 instance: records each cs_n-low window.
    int          acc_cnt = 0, done_cnt = 0, sclk_bad = 0;
    int          low_run = 0, high_run = 0, nbits = 0;
    logic [15:0] cap = '0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [15:0] words[$];
    int          lows[$], nbitsq[$], gaps[$];

    always @(posedge clk) begin
        if (sample_valid && sample_ready) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
        if (cs_n === 1'b1 && sclk !== 1'b0) sclk_bad <= sclk_bad + 1;
        if (cs_n === 1'b0) begin
            if (prev_cs === 1'b1) begin
                gaps.push_back(high_run);
                low_run <= 1;
                cap     <= '0;
                nbits   <= 0;
            end else begin
                low_run <= low_run + 1;
                if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                    cap   <= {cap[14:0], mosi};
                    nbits <= nbits + 1;
                end
            end
        end else if (cs_n === 1'b1) begin
            if (prev_cs === 1'b0) begin
                words.push_back(cap);
                lows.push_back(low_run);
                nbitsq.push_back(nbits);
                high_run <= 1;
            end else begin
                high_run <= high_run + 1;
            end
        end
        prev_cs   <= cs_n;
        prev_sclk <= sclk;
    end

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (sample_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (sample_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; rst1 = 1'b1;
        sample_valid = 1'b1; sample_in = 8'h77;
        sample_valid1 = 1'b0; sample_in1 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({cs_n, sclk, mosi, sample_ready, busy, frame_done} !== 6'b100000) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got cs/sclk/mosi/rdy/busy/done=%b want 100000", i,
                         {cs_n, sclk, mosi, sample_ready, busy, frame_done});
            end
        end
        rst = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (sample_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", sample_ready);
        end
        total++;
        if (sample_ready1 !== 1'b1 || cs_n !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_div1: got ready1=%b cs_n=%b want 1 1", sample_ready1, cs_n);
        end
        sample_valid = 1'b0;
`ifdef DAC_SPI_LDAC_EN
        total++;
        if (ldac_n !== 1'b1) begin
            bad++;
            $display("FAIL reset_ldac: got %b want 1", ldac_n);
        end
`endif
        $display("reset: rst held 3 cycles, ready after release=%b", sample_ready);
    endtask

    task automatic test_single(input logic [7:0] s, input logic [15:0] exp_word);
        int base_w, base_done, n;
        bit ok;
        base_w = words.size();
        base_done = done_cnt;
        wait_ready(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_ready_timeout: ready=%b want 1", sample_ready);
        end
        sample_in = s; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        total++;
        if (cs_n !== 1'b0 || busy !== 1'b1 || sample_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_after_accept: got cs_n=%b busy=%b ready=%b want 0 1 0", cs_n, busy, sample_ready);
        end
        n = 0;
        while (sample_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != 70) begin
            bad++;
            $display("FAIL single_ready_latency: got %0d want 70", n);
        end
        total++;
        if (words.size() != base_w + 1) begin
            bad++;
            $display("FAIL single_frame_count: got %0d want 1", words.size() - base_w);
        end else begin
            total++;
            if (words[base_w] !== exp_word) begin
                bad++;
                $display("FAIL single_word: got %h want %h", words[base_w], exp_word);
            end
            total++;
            if (lows[base_w] != 68 || nbitsq[base_w] != 16) begin
                bad++;
                $display("FAIL single_cs_low: got low=%0d bits=%0d want 68 16", lows[base_w], nbitsq[base_w]);
            end
        end
        total++;
        if (done_cnt - base_done != 1) begin
            bad++;
            $display("FAIL single_frame_done: got %0d pulses want 1", done_cnt - base_done);
        end
        $display("single: sample=%h latency=%0d frames=%0d", s, n, words.size() - base_w);
    endtask

    task automatic test_back_to_back();
        int base_w, base_g, base_acc, n;
        bit ok;
        base_w = words.size();
        base_g = gaps.size();
        base_acc = acc_cnt;
        wait_ready(ok);
        sample_in = 8'h00; sample_valid = 1'b1;
        n = 0;
        while (acc_cnt - base_acc < 2 && n < 400) begin
            @(posedge clk); #1;
            if (acc_cnt - base_acc >= 1) sample_in = 8'hFF;
            n++;
        end
        sample_valid = 1'b0;
        wait_ready(ok);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (acc_cnt - base_acc != 2) begin
            bad++;
            $display("FAIL b2b_accepts: got %0d want 2", acc_cnt - base_acc);
        end
        total++;
        if (words.size() < base_w + 2 || gaps.size() < base_g + 2) begin
            bad++;
            $display("FAIL b2b_frames: got %0d want 2", words.size() - base_w);
        end else begin
            total++;
            if (words[base_w] !== 16'h3000 || words[base_w+1] !== 16'h3FF0) begin
                bad++;
                $display("FAIL b2b_words: got %h %h want 3000 3ff0", words[base_w], words[base_w+1]);
            end
            total++;
            if (gaps[base_g+1] < 2) begin
                bad++;
                $display("FAIL b2b_gap: got %0d cycles want >=2", gaps[base_g+1]);
            end
        end
        $display("b2b: accepts=%0d frames=%0d", acc_cnt - base_acc, words.size() - base_w);
    endtask

    task automatic test_hold();
        int base_w, base_acc, n;
        bit ok;
        base_w = words.size();
        base_acc = acc_cnt;
        wait_ready(ok);
        sample_in = 8'hC3; sample_valid = 1'b1;
        @(posedge clk); #1;
        n = 0;
        // Upstream keeps valid high and scrambles data; none of it may leak into the frame.
        while (sample_ready !== 1'b1 && n < 200) begin
            sample_in = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        sample_valid = 1'b0;
        total++;
        if (acc_cnt - base_acc != 1) begin
            bad++;
            $display("FAIL hold_accepts: got %0d want 1", acc_cnt - base_acc);
        end
        total++;
        if (words.size() != base_w + 1) begin
            bad++;
            $display("FAIL hold_frame_count: got %0d want 1", words.size() - base_w);
        end else begin
            total++;
            if (words[base_w] !== 16'h3C30) begin
                bad++;
                $display("FAIL hold_word: got %h want 3c30", words[base_w]);
            end
        end
        $display("hold: accepts=%0d", acc_cnt - base_acc);
    endtask

    task automatic test_abort();
        int base_done, rises, n;
        logic prev;
        bit ok;
        base_done = done_cnt;
        wait_ready(ok);
        sample_in = 8'h96; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        rises = 0; n = 0; prev = sclk;
        while (rises < 8 && n < 200) begin
            @(posedge clk); #1;
            if (sclk === 1'b1 && prev === 1'b0) rises++;
            prev = sclk;
            n++;
        end
        total++;
        if (rises != 8) begin
            bad++;
            $display("FAIL abort_rises: got %0d want 8", rises);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({cs_n, sclk, mosi, busy, sample_ready} !== 5'b10000) begin
            bad++;
            $display("FAIL abort_outputs: got cs/sclk/mosi/busy/rdy=%b want 10000",
                     {cs_n, sclk, mosi, busy, sample_ready});
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (done_cnt != base_done) begin
            bad++;
            $display("FAIL abort_frame_done: got %0d pulses want 0", done_cnt - base_done);
        end
        $display("abort: rst at sclk rise %0d", rises);
        test_single(8'h5A, 16'h35A0);
    endtask

    task automatic test_div1();
        int n, rise1, rise2, cs_low, cs_rise, done1, ldac_low, ldac_at;
        logic [15:0] word;
        logic prev_s, prev_c;
        int guard;
        guard = 0;
        while (sample_ready1 !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        sample_in1 = 8'h3C; sample_valid1 = 1'b1;
        @(posedge clk); #1;
        sample_valid1 = 1'b0;
        n = 0; rise1 = -1; rise2 = -1; cs_low = 0; cs_rise = -1; done1 = 0;
        ldac_low = 0; ldac_at = -1; word = '0; prev_s = 1'b0; prev_c = 1'b0;
        while (1) begin
            if (cs_n1 === 1'b0) cs_low++;
            if (cs_n1 === 1'b1 && prev_c === 1'b0) cs_rise = n;
            if (sclk1 === 1'b1 && prev_s === 1'b0) begin
                word = {word[14:0], mosi1};
                if (rise1 < 0) rise1 = n;
                else if (rise2 < 0) rise2 = n;
            end
            if (frame_done1 === 1'b1) done1++;
`ifdef DAC_SPI_LDAC_EN
            if (ldac_n1 === 1'b0) begin
                ldac_low++;
                ldac_at = n;
            end
`endif
            prev_s = sclk1; prev_c = cs_n1;
            if (sample_ready1 === 1'b1 || n >= 100) break;
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != 35) begin
            bad++;
            $display("FAIL div1_ready_latency: got %0d want 35", n);
        end
        total++;
        if (rise2 - rise1 != 2 || rise1 != 1) begin
            bad++;
            $display("FAIL div1_sclk_period: got first=%0d period=%0d want 1 2", rise1, rise2 - rise1);
        end
        total++;
        if (word !== 16'h33C0) begin
            bad++;
            $display("FAIL div1_word: got %h want 33c0", word);
        end
        total++;
        if (cs_low != 34 || cs_rise != 34 || done1 != 1) begin
            bad++;
            $display("FAIL div1_cs_timing: got low=%0d rise=%0d done=%0d want 34 34 1", cs_low, cs_rise, done1);
        end
`ifdef DAC_SPI_LDAC_EN
        total++;
        if (ldac_low != 1 || ldac_at != cs_rise) begin
            bad++;
            $display("FAIL div1_ldac: got low_cycles=%0d at=%0d want 1 at %0d", ldac_low, ldac_at, cs_rise);
        end
`endif
        $display("div1: word=%h latency=%0d ldac_low=%0d", word, n, ldac_low);
    endtask

    initial begin
        test_reset();
        test_single(8'hA5, 16'h3A50);
        test_back_to_back();
        test_hold();
        test_abort();
        test_div1();
        total++;
        if (sclk_bad != 0) begin
            bad++;
            $display("FAIL sclk_idle_low: got %0d cycles with sclk high while deselected want 0", sclk_bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
